// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Lines are 32 bytes (8 words). A miss freezes the pipeline while the dirty victim
// is written back (if needed) and the missing line is fetched. The held request
// then hits in IDLE on the cycle after the refill.
// Optional feature: define DCACHE_STATS_EN to add the hit_cnt_o/miss_cnt_o counters.
module dcache_ctrl #(
  parameter int INDEX_W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic         we_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  wdata_i,
  output logic [31:0]  rdata_o,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 32 - INDEX_W - 5;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state_q, state_d;

  // Storage: the data and tag arrays carry no reset, only valid/dirty do.
  logic [255:0]     data_mem [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  // Address of the access that missed; keeps the memory-side outputs steady
  // for the whole transfer even if the CPU misbehaves and drops the request.
  logic [31:0] miss_addr_q;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [2:0]         req_word;
  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_idx;

  logic hit;
  logic idle_hit;
  logic store_hit;
  logic miss_start;
  logic refill_en;
  logic unused_addr_bits;

  assign req_tag  = addr_i[31:INDEX_W+5];
  assign req_idx  = addr_i[INDEX_W+4:5];
  assign req_word = addr_i[4:2];
  assign miss_tag = miss_addr_q[31:INDEX_W+5];
  assign miss_idx = miss_addr_q[INDEX_W+4:5];

  // Byte offsets are meaningless to a word cache, and the miss address is line-aligned.
  assign unused_addr_bits = ^{addr_i[1:0], miss_addr_q[4:0]};

  assign hit       = req_i && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign idle_hit  = (state_q == IDLE) && hit;
  assign store_hit = idle_hit && we_i;

  // Load data is a straight combinational word select from the indexed line.
  assign rdata_o = data_mem[req_idx][{req_word, 5'b00000} +: 32];

  // State register and miss-address capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      miss_addr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        miss_addr_q <= {addr_i[31:5], 5'b00000};
      end
    end
  end

  // Next-state logic and all pipeline/memory-side outputs.
  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {miss_addr_q[31:5], 5'b00000};
    mem_wdata_o = data_mem[miss_idx];
    miss_start  = 1'b0;
    refill_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_i && req_i && !hit) begin
          stall_o    = 1'b1;
          miss_start = 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {tag_mem[miss_idx], miss_idx, 5'b00000};
        if (mem_ack_i) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          refill_en = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line data and tag updates: whole-line refill or a single-word store hit.
  always_ff @(posedge clk_i) begin
    if (refill_en) begin
      data_mem[miss_idx] <= mem_rdata_i;
      tag_mem[miss_idx]  <= miss_tag;
    end else if (store_hit) begin
      data_mem[req_idx][{req_word, 5'b00000} +: 32] <= wdata_i;
    end
  end

  // Valid and dirty bookkeeping; a refill yields a clean line, a store marks it dirty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (refill_en) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic retry_q;

  // Hit/miss counters; the hit that retries a just-refilled request is not a real hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retry_q    <= 1'b0;
      hit_cnt_o  <= 32'd0;
      miss_cnt_o <= 32'd0;
    end else begin
      retry_q <= refill_en;
      if (miss_start) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
      if (idle_hit && !retry_q) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have parameter INDEX_W, default 5, giving log2 of the line count (32 lines).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_i, input, 1 bit: CPU MEM-stage access request.
REQ-005 The block SHALL have port we_i, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have port addr_i, input, 32 bits: byte address; [1:0] ignored; [4:2] word; [INDEX_W+4:5] index; [31:INDEX_W+5] tag.
REQ-007 The block SHALL have port wdata_i, input, 32 bits: store data.
REQ-008 The block SHALL have port rdata_o, output, 32 bits: load data.
REQ-009 The block SHALL have port stall_o, output, 1 bit: pipeline freeze; the CPU holds req_i/we_i/addr_i/wdata_i stable while it is 1.
REQ-010 The block SHALL have ports mem_req_o (out, 1), mem_we_o (out, 1), mem_addr_o (out, 32, line-aligned), mem_wdata_o (out, 256), mem_rdata_i (in, 256), mem_ack_i (in, 1, one-cycle pulse).

Function
REQ-011 Organisation: direct-mapped, 32-byte lines, write-back, write-allocate; per line valid bit, dirty bit, tag.
REQ-012 FSM states: IDLE, WRITEBACK, ALLOCATE.
REQ-013 IDLE hit (req_i, valid, tag equal): stall_o=0 same cycle; load returns the selected word combinationally; store writes the word and sets dirty at the next edge.
REQ-014 IDLE miss: stall_o=1 same cycle; next state WRITEBACK if the victim is valid and dirty, else ALLOCATE.
REQ-015 WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_wdata_o=victim line; on mem_ack_i go to ALLOCATE.
REQ-016 ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={addr_i[31:5], 5'b0}; on mem_ack_i write mem_rdata_i to the line, set valid=1, dirty=0, update the tag, go to IDLE.
REQ-017 stall_o SHALL be 1 throughout WRITEBACK and ALLOCATE; the held request hits in IDLE the cycle after refill, giving a clean-miss latency of 2 + memory latency cycles.
REQ-018 mem_req_o and all mem_* outputs SHALL stay stable until mem_ack_i; mem_ack_i is ignored in IDLE.
REQ-019 req_i=0 in IDLE: no state change, stall_o=0, rdata_o don't-care.
REQ-020 If req_i drops during a miss (illegal), the current transfer SHALL still complete and the FSM returns to IDLE.
REQ-021 mem_ack_i arriving on the same edge as the state entry is legal and is consumed.

Reset
REQ-022 While rst_i=0: state=IDLE, all valid and dirty bits=0, mem_req_o=0, mem_we_o=0, stall_o=0; the data and tag arrays are not reset.
REQ-023 Reset mid-transfer SHALL abandon the transaction: mem_req_o drops immediately and no line is updated.

Configuration
REQ-024 With DCACHE_STATS_EN defined, the block SHALL add 32-bit outputs hit_cnt_o and miss_cnt_o, reset to 0 and wrapping at 2^32.
REQ-025 Under DCACHE_STATS_EN, miss_cnt_o SHALL increment once per IDLE-to-non-IDLE transition.
REQ-026 Under DCACHE_STATS_EN, hit_cnt_o SHALL increment per IDLE hit, excluding the retry hit immediately after ALLOCATE.
REQ-027 Without DCACHE_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Load 0x0000_0040 after reset -> stall 1, ALLOCATE with mem_addr_o=0x40; ack after 5 cycles -> next cycle stall_o=0, rdata_o=mem_rdata_i[31:0].
REQ-029 Store 0xDEADBEEF to 0x44 (line resident), then load 0x44 -> no stall, rdata_o=0xDEADBEEF, dirty set.
REQ-030 With line 0x40 dirty, load 0x0000_0440 (same index, different tag) -> WRITEBACK with mem_addr_o=0x40 and word1=0xDEADBEEF, then ALLOCATE with mem_addr_o=0x440.
REQ-031 rst_i low during ALLOCATE -> mem_req_o=0 immediately; a later ack is ignored; a load of the same address misses again.
REQ-032 With DCACHE_STATS_EN: 1 miss + 3 hits -> miss_cnt_o=1, hit_cnt_o=3; preload hit_cnt_o=0xFFFFFFFF, one hit -> 0.
REQ-033 Ack in the first ALLOCATE cycle -> refill is accepted and the total stall is 2 cycles.
